// File: rtl/hazard_ctrl.sv
// Hazard controller for the RV32I 5-stage pipeline: load-use stalls, branch flushes,
// EX operand forwarding selects and stall/flush performance counters.
module hazard_ctrl #(
    parameter int         LOAD_LATENCY = 1,
    parameter int         CNT_W        = 32,
    parameter logic [1:0] LD_SEL       = 2'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic             RF_WENE,
    input  logic [1:0]       sel_ldE,
    input  logic             br_takenE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             RF_WENM,
    input  logic             RF_WENW,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [2:0]       BUB_INIT = 3'(LOAD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_bub;
    logic [2:0]       w_bub_nxt;
    logic             w_lu_hit;
    logic             w_stall;
    logic             w_flushD;
    logic             w_flushE;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // MEM result beats WB result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wen_m,
        input logic [4:0] rd_w,
        input logic       wen_w
    );
        if (wen_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wen_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign w_lu_hit = RF_WENE && (sel_ldE == LD_SEL) && (rdE != 5'd0) &&
                      ((rdE == rs1D) || (rdE == rs2D));

    // Next-state and stall/flush decode; a taken branch always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_bub_nxt   = r_bub;
        w_stall     = 1'b0;
        w_flushD    = 1'b0;
        w_flushE    = 1'b0;
        case (r_state)
            IDLE: begin
                if (br_takenE) begin
                    w_flushD = 1'b1;
                    w_flushE = 1'b1;
                end else if (w_lu_hit) begin
                    w_stall  = 1'b1;
                    w_flushE = 1'b1;
                    if (LOAD_LATENCY > 1) begin
                        w_state_nxt = STALL;
                        w_bub_nxt   = BUB_INIT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            STALL: begin
                if (br_takenE) begin
                    w_flushD    = 1'b1;
                    w_flushE    = 1'b1;
                    w_state_nxt = IDLE;
                    w_bub_nxt   = 3'd0;
                end else begin
                    w_stall  = 1'b1;
                    w_flushE = 1'b1;
                    if (r_bub <= 3'd1) begin
                        w_state_nxt = IDLE;
                        w_bub_nxt   = 3'd0;
                    end else begin
                        w_bub_nxt = r_bub - 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_bub_nxt   = 3'd0;
            end
        endcase
    end

    // FSM state and bubble counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_bub   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bub   <= w_bub_nxt;
        end
    end

    // Performance counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stallD) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (flushD) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    // Gating with rst keeps the pipeline registers free-running while reset is held.
    assign stallF    = rst & w_stall;
    assign stallD    = rst & w_stall;
    assign flushD    = rst & w_flushD;
    assign flushE    = rst & w_flushE;
    assign busy      = (r_state == STALL);
    assign fwdAE     = fwd_sel(rs1E, rdM, RF_WENM, rdW, RF_WENW);
    assign fwdBE     = fwd_sel(rs2E, rdM, RF_WENM, rdW, RF_WENW);
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (latency 1, latency 3, 4-bit counters)
// share one stimulus stream; expected values are hand-computed.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       RF_WENE, RF_WENM, RF_WENW, br_takenE;
    logic [1:0] sel_ldE;

    logic        a_stallF, a_stallD, a_flushD, a_flushE, a_busy;
    logic [1:0]  a_fwdA, a_fwdB;
    logic [31:0] a_scnt, a_fcnt;
    logic        b_stallF, b_stallD, b_flushD, b_flushE, b_busy;
    logic [1:0]  b_fwdA, b_fwdB;
    logic [31:0] b_scnt, b_fcnt;
    logic        c_stallF, c_stallD, c_flushD, c_flushE, c_busy;
    logic [1:0]  c_fwdA, c_fwdB;
    logic [3:0]  c_scnt, c_fcnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LATENCY(1), .CNT_W(32), .LD_SEL(2'd1)) u_l1 (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .RF_WENE(RF_WENE), .sel_ldE(sel_ldE), .br_takenE(br_takenE),
        .rdM(rdM), .rdW(rdW), .RF_WENM(RF_WENM), .RF_WENW(RF_WENW),
        .stallF(a_stallF), .stallD(a_stallD), .flushD(a_flushD), .flushE(a_flushE),
        .fwdAE(a_fwdA), .fwdBE(a_fwdB), .stall_cnt(a_scnt), .flush_cnt(a_fcnt), .busy(a_busy));

    hazard_ctrl #(.LOAD_LATENCY(3), .CNT_W(32), .LD_SEL(2'd1)) u_l3 (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .RF_WENE(RF_WENE), .sel_ldE(sel_ldE), .br_takenE(br_takenE),
        .rdM(rdM), .rdW(rdW), .RF_WENM(RF_WENM), .RF_WENW(RF_WENW),
        .stallF(b_stallF), .stallD(b_stallD), .flushD(b_flushD), .flushE(b_flushE),
        .fwdAE(b_fwdA), .fwdBE(b_fwdB), .stall_cnt(b_scnt), .flush_cnt(b_fcnt), .busy(b_busy));

    hazard_ctrl #(.LOAD_LATENCY(1), .CNT_W(4), .LD_SEL(2'd1)) u_w4 (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .RF_WENE(RF_WENE), .sel_ldE(sel_ldE), .br_takenE(br_takenE),
        .rdM(rdM), .rdW(rdW), .RF_WENM(RF_WENM), .RF_WENW(RF_WENW),
        .stallF(c_stallF), .stallD(c_stallD), .flushD(c_flushD), .flushE(c_flushE),
        .fwdAE(c_fwdA), .fwdBE(c_fwdB), .stall_cnt(c_scnt), .flush_cnt(c_fcnt), .busy(c_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
        rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
        RF_WENE = 1'b0; RF_WENM = 1'b0; RF_WENW = 1'b0;
        br_takenE = 1'b0; sel_ldE = 2'd0;
    endtask

    task automatic load_use();
        RF_WENE = 1'b1; sel_ldE = 2'd1; rdE = 5'd5; rs2D = 5'd5; rs1D = 5'd0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset held with both a load-use hazard and a branch driven.
        clr_inputs();
        rst = 1'b0;
        load_use();
        br_takenE = 1'b1;
        #1;
        tick();
        tick();
        chk("rst_stallF", {31'd0, a_stallF}, 32'd0);
        chk("rst_stallD", {31'd0, b_stallD}, 32'd0);
        chk("rst_flushD", {31'd0, a_flushD}, 32'd0);
        chk("rst_flushE", {31'd0, b_flushE}, 32'd0);
        chk("rst_busy",   {31'd0, b_busy},   32'd0);
        chk("rst_scnt",   a_scnt,            32'd0);
        chk("rst_fcnt",   b_fcnt,            32'd0);
        rst = 1'b1;
        #1;
        chk("rel_flushD", {31'd0, a_flushD}, 32'd1);
        chk("rel_flushE", {31'd0, a_flushE}, 32'd1);
        chk("rel_stallD", {31'd0, a_stallD}, 32'd0);
        tick();
        clr_inputs();
        #1;
        chk("rel_fcnt", a_fcnt, 32'd1);
        chk("rel_scnt", a_scnt, 32'd0);

        // Load-use at latency 1 and latency 3.
        do_reset();
        load_use();
        #1;
        chk("lu1_stallF", {31'd0, a_stallF}, 32'd1);
        chk("lu1_stallD", {31'd0, a_stallD}, 32'd1);
        chk("lu1_flushE", {31'd0, a_flushE}, 32'd1);
        chk("lu1_flushD", {31'd0, a_flushD}, 32'd0);
        chk("lu3_c1_busy", {31'd0, b_busy},  32'd0);
        chk("lu3_c1_stallD", {31'd0, b_stallD}, 32'd1);
        tick();
        RF_WENE = 1'b0;
        #1;
        chk("lu1_after_stallD", {31'd0, a_stallD}, 32'd0);
        chk("lu1_after_busy",   {31'd0, a_busy},   32'd0);
        chk("lu1_scnt",         a_scnt,            32'd1);
        chk("lu3_c2_stallD",    {31'd0, b_stallD}, 32'd1);
        chk("lu3_c2_busy",      {31'd0, b_busy},   32'd1);
        chk("lu3_c2_scnt",      b_scnt,            32'd1);
        tick();
        chk("lu3_c3_stallD",    {31'd0, b_stallD}, 32'd1);
        chk("lu3_c3_busy",      {31'd0, b_busy},   32'd1);
        chk("lu3_c3_scnt",      b_scnt,            32'd2);
        tick();
        chk("lu3_end_stallD",   {31'd0, b_stallD}, 32'd0);
        chk("lu3_end_busy",     {31'd0, b_busy},   32'd0);
        chk("lu3_end_scnt",     b_scnt,            32'd3);
        chk("lu1_end_scnt",     a_scnt,            32'd1);

        // Branch on the second stall cycle aborts the stall.
        do_reset();
        load_use();
        #1;
        tick();
        RF_WENE = 1'b0;
        br_takenE = 1'b1;
        #1;
        chk("brs_flushD", {31'd0, b_flushD}, 32'd1);
        chk("brs_flushE", {31'd0, b_flushE}, 32'd1);
        chk("brs_stallD", {31'd0, b_stallD}, 32'd0);
        chk("brs_stallF", {31'd0, b_stallF}, 32'd0);
        tick();
        br_takenE = 1'b0;
        #1;
        chk("brs_busy",   {31'd0, b_busy},   32'd0);
        chk("brs_idle_stallD", {31'd0, b_stallD}, 32'd0);
        chk("brs_fcnt",   b_fcnt,            32'd1);
        chk("brs_scnt",   b_scnt,            32'd1);

        // Reset asserted mid-stall.
        do_reset();
        load_use();
        #1;
        tick();
        RF_WENE = 1'b0;
        #1;
        chk("mid_busy_pre", {31'd0, b_busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_busy_rst",   {31'd0, b_busy},   32'd0);
        chk("mid_stallD_rst", {31'd0, b_stallD}, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_stallD_rel", {31'd0, b_stallD}, 32'd0);
        tick();
        chk("mid_busy_rel",   {31'd0, b_busy},   32'd0);

        // x0 and non-load writers never stall.
        clr_inputs();
        RF_WENE = 1'b1; sel_ldE = 2'd1;
        #1;
        chk("x0_stallD", {31'd0, a_stallD}, 32'd0);
        sel_ldE = 2'd2; rdE = 5'd5; rs2D = 5'd5;
        #1;
        chk("noload_stallD", {31'd0, a_stallD}, 32'd0);
        clr_inputs();

        // Forwarding priority.
        rs1E = 5'd7; rdM = 5'd7; RF_WENM = 1'b1; rdW = 5'd7; RF_WENW = 1'b1; rs2E = 5'd3;
        #1;
        chk("fwdA_mem", {30'd0, a_fwdA}, 32'd2);
        chk("fwdB_none", {30'd0, a_fwdB}, 32'd0);
        RF_WENM = 1'b0;
        #1;
        chk("fwdA_wb", {30'd0, a_fwdA}, 32'd1);
        rdW = 5'd0;
        #1;
        chk("fwdA_rf", {30'd0, a_fwdA}, 32'd0);
        rs1E = 5'd0; rdM = 5'd0; RF_WENM = 1'b1;
        #1;
        chk("fwdA_x0", {30'd0, a_fwdA}, 32'd0);
        rs2E = 5'd9; rdW = 5'd9; RF_WENW = 1'b1;
        #1;
        chk("fwdB_wb", {30'd0, b_fwdB}, 32'd1);
        clr_inputs();

        // 17 load-use hazards wrap the 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            load_use();
            tick();
            RF_WENE = 1'b0;
            tick();
        end
        chk("wrap_w4_scnt", {28'd0, c_scnt}, 32'd1);
        chk("wrap_l1_scnt", a_scnt, 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32I 5-stage core. It reads the EX-side outputs of the ID/EX pipeline registers (rs1E, rs2E, rdE, RF_WENE, sel_ldE) together with the ID, MEM and WB register names. From these it drives stall and flush back into the IF/ID and ID/EX registers and selects the forwarding paths for the EX operands. A small FSM inserts a configurable number of load-use bubbles, and two counters record stall and flush cycles for performance analysis.

## Interface
- LOAD_LATENCY, 1: bubbles inserted per load-use hazard (1..7)
- CNT_W, 32: width of the performance counters
- LD_SEL, 2'd1: sel_ldE encoding that marks a data-memory load
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- rs1D, rs2D  in  5  source registers of the instruction in ID
- rs1E, rs2E, rdE  in  5  register names of the instruction in EX
- RF_WENE  in  1  EX instruction writes the RF
- sel_ldE  in  2  EX RF write-source select
- br_takenE  in  1  branch/jump in EX redirects the PC
- rdM, rdW  in  5  destination registers in MEM and WB
- RF_WENM, RF_WENW  in  1  MEM/WB instructions write the RF
- stallF, stallD  out  1  hold the PC and the IF/ID register
- flushD, flushE  out  1  synchronous clear of IF/ID and ID/EX (drives their rst)
- fwdAE, fwdBE  out  2  EX operand source: 00 = register file, 01 = WB result, 10 = MEM ALU result
- stall_cnt, flush_cnt  out  CNT_W  performance counters
- busy  out  1  FSM is in STALL

## Operation
- lu_hit = RF_WENE & (sel_ldE==LD_SEL) & (rdE!=0) & ((rdE==rs1D) | (rdE==rs2D)).
- FSM states: IDLE, STALL. An internal down-counter bub (3 bits) tracks the remaining bubbles.
- IDLE, priority order:
  - br_takenE=1: flushD=1, flushE=1, stall outputs 0, stay IDLE. The branch wins over lu_hit.
  - lu_hit=1: stallF=stallD=flushE=1. If LOAD_LATENCY>1, go to STALL with bub=LOAD_LATENCY-1. Otherwise stay IDLE.
  - Otherwise all stall/flush outputs are 0.
- STALL:
  - Outputs stallF=stallD=flushE=1 and busy=1.
  - bub decrements each cycle. When bub==1, return to IDLE on the next edge.
  - If br_takenE=1 in STALL: apply the branch outputs (flushD=flushE=1, stall outputs 0), abort the stall and return to IDLE.
- lu_hit in STALL is ignored because EX holds a bubble.
- Forwarding is combinational and independent of the FSM, shown here for A (B is identical using rs2E):
  - 10 if RF_WENM & rdM!=0 & rdM==rs1E
  - else 01 if RF_WENW & rdW!=0 & rdW==rs1E
  - else 00
  - MEM takes priority over WB.
- Counters:
  - stall_cnt increments on every edge where stallD=1.
  - flush_cnt increments on every edge where flushD=1.
  - Both wrap modulo 2^CNT_W.
- x0 never causes a hazard or a forward.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, bub=0, stall_cnt=flush_cnt=0, busy=0.
  - stallF, stallD, flushD and flushE are forced to 0 while rst=0, regardless of the inputs.
  - fwdAE/fwdBE remain combinational.
- Reset asserted mid-STALL aborts the stall immediately. After release, the next cycle evaluates as IDLE.
- stall/flush/fwd outputs are combinational from state and inputs in the same cycle. The pipeline registers sample them at the next edge.
- The load-use penalty is exactly LOAD_LATENCY cycles of stallD=1, counted from the first cycle lu_hit is seen.
- The branch penalty is 2 cycles: the IF/ID and ID/EX contents are flushed at the same edge.
- Counter increments are visible one cycle after the qualifying cycle.

## Test plan
- Reset values: hold rst=0 with lu_hit and br_takenE both driven -> all stall/flush outputs 0, counters 0, busy=0. Release rst -> outputs follow the inputs in the next cycle.
- Load-use, LOAD_LATENCY=1: rdE=5, sel_ldE=1, RF_WENE=1, rs2D=5 -> stallF=stallD=flushE=1 for 1 cycle, state stays IDLE, stall_cnt=1.
- Load-use, LOAD_LATENCY=3: same stimulus -> 3 consecutive stall cycles, busy=1 for the last 2, stall_cnt=3, then IDLE.
- Branch during STALL: on the 2nd stall cycle assert br_takenE -> flushD=flushE=1, stallD=0, FSM back to IDLE, flush_cnt=1, stall_cnt=1.
- Forwarding priority: rs1E=7, rdM=7, RF_WENM=1, rdW=7, RF_WENW=1 -> fwdAE=10. Set RF_WENM=0 -> 01. Set rdW=0 -> 00. Set rs1E=0 with a matching rdM=0 -> 00.
- Counter wrap, CNT_W=4: 17 load-use hazards at LOAD_LATENCY=1 -> stall_cnt=1.
